i2c_master: RTL and testbench
=============================

# i2c_master

Single-byte I2C bus master that generates START, 7-bit address + R/W, one data byte (write or read), ACK/NACK handling and STOP on the SCL/SDA lines consumed by the I2C slave. It sits between a register-level command interface (CPU/testbench) and the top-level SDA IOBUF. SCL is driven push-pull. SDA uses the same tri-state control convention as the slave: SDA_in_en high releases the line.

## Interface
Parameters:
- CLK_DIV, 250, clk cycles per SCL quarter-bit slot; legal values ≥2; SCL period = 4*CLK_DIV clk cycles.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- cmd_start  in  1  one-cycle request; sampled only when busy=0
- cmd_addr  in  7  target slave address
- cmd_rw  in  1  0=write, 1=read
- cmd_wdata  in  8  byte to write (ignored on read)
- busy  out  1  high from the cycle after an accepted cmd_start until done
- done  out  1  one-cycle pulse at transaction end
- ack_err  out  1  set at done if any slave ACK slot read high; held until next accepted command
- rdata  out  8  read byte, updated at done of a read with no address NACK
- SCL_o  out  1  SCL drive
- SDA_i  in  1  SDA input from IOBUF
- SDA_o  out  1  SDA drive value, 0 whenever driving
- SDA_in_en  out  1  1=release SDA (tri-state), 0=drive SDA_o

## Operation
- Quarter counter runs 0..CLK_DIV-1. Each "slot" = 4 quarters q0..q3. Bit counter is 3 bits, wraps 7→0.
- Command latching: cmd_addr, cmd_rw and cmd_wdata are latched on acceptance, clearing ack_err. Changes to the cmd inputs while busy have no effect. cmd_start while busy is ignored.
- States: IDLE, START, ADDR, AACK, WRITE, WACK, READ, MACK, STOP.
- IDLE: SCL_o=1, SDA released. An accepted cmd_start moves to START.
- START: q0–q1 SCL high, SDA released. q2–q3 SCL high, SDA driven 0. Then go to ADDR.
- Data bit slots (ADDR, WRITE, READ, and the ack slots):
  - q0–q1: SCL low; SDA updated at q0 start.
  - q2–q3: SCL high.
  - SDA_i is sampled on the last clk of q2.
- ADDR: 8 slots, {addr, rw}, MSB first. Drive 0 for a 0 bit; release for a 1 bit.
- AACK: SDA released; sample the ACK.
  - High: set ack_err and go to STOP.
  - Else: go to WRITE if rw=0, READ if rw=1.
- WRITE: 8 slots of wdata, MSB first, then WACK. WACK: sample; high sets ack_err. Then STOP.
- READ: SDA released for 8 slots. The shift register takes {sr[6:0], SDA_i} at each sample. Then MACK.
- MACK: SDA released (master NACK, single-byte read). Then STOP.
- STOP:
  - q0: SCL low, SDA driven 0.
  - q1: SCL high, SDA 0.
  - q2: SCL high, SDA released.
  - q3: idle.
- End of transaction: on the last clk of STOP q3, register done=1 and busy=0 for the next cycle, load rdata (read), and return to IDLE.
- No clock stretching, arbitration or repeated start.

## Timing
- Reset (async assert, any state) values: SCL_o=1, SDA_in_en=1, SDA_o=1, busy=0, done=0, ack_err=0, rdata=0, state=IDLE, counters=0. Deassertion is synchronous to clk.
- Reset mid-transaction releases the bus immediately; no STOP is generated.
- busy rises 1 cycle after accepted cmd_start.
- Full transaction: 20 slots = 80*CLK_DIV cycles from acceptance to done (START + 8 + 1 + 8 + 1 + STOP).
- Address NACK: 11 slots = 44*CLK_DIV cycles.
- cmd_start in the same cycle as done: ignored, because busy is still considered high that cycle. It is accepted from the next cycle.
- All outputs are registered; SCL_o/SDA transitions occur at slot-quarter boundaries only.
- SDA never changes while SCL_o=1, except the START/STOP edges.

## Test plan
- Write with CLK_DIV=4: addr 0x53, rw=0, wdata 0xA5; bench slave ACKs both. Required:
  - SDA bit sequence 1010011_0 then 10100101.
  - done at cycle 320 after acceptance; ack_err=0.
- Read with CLK_DIV=4: addr 0x53, rw=1; slave ACKs and drives 0x7E MSB first. Required:
  - rdata=0x7E at done.
  - Master releases SDA in the MACK slot.
  - STOP generated; ack_err=0.
- Address NACK: addr 0x21, no slave responds. Required:
  - STOP immediately after AACK.
  - done after 44*CLK_DIV cycles; ack_err=1; rdata unchanged.
- Protocol checker over all runs: SDA stable while SCL high except exactly one START (SDA 1→0) and one STOP (SDA 0→1) per transaction.
- cmd_start while busy, and in the done cycle, with different cmd_addr: ignored, no second transaction. cmd_start one cycle later is accepted.
- Assert rstn low during the WRITE data slot 3. Required:
  - Same cycle, asynchronously: SCL_o=1, SDA_in_en=1, busy=0, done=0.
  - After release, a new write completes normally.

Source files
------------

// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master
// Brief    : Single-byte I2C master: START, 7-bit address + R/W, one data
//            byte (write or read), ACK/NACK handling and STOP.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_start,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    output logic       SCL_o,
    input  logic       SDA_i,
    output logic       SDA_o,
    output logic       SDA_in_en
);

    localparam int                 c_CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_AACK  = 4'd3,
        S_WRITE = 4'd4,
        S_WACK  = 4'd5,
        S_READ  = 4'd6,
        S_MACK  = 4'd7,
        S_STOP  = 4'd8
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]         r_q, w_q_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic [7:0]         r_addr_byte, r_wdata, r_sr, r_rdata;
    logic               r_nack, r_busy, r_done, r_ack_err, r_scl, r_sda_rel;
    logic               w_accept, w_cnt_end, w_sample, w_slot_end, w_done_nxt;
    logic               w_scl_nxt, w_rel_nxt;

    // done-cycle still counts as busy for command acceptance
    always_comb begin
        w_accept   = cmd_start && (r_state == S_IDLE) && !r_done;
        w_cnt_end  = (r_cnt == c_CNT_MAX);
        w_sample   = w_cnt_end && (r_q == 2'd2);
        w_slot_end = w_cnt_end && (r_q == 2'd3);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_accept) w_state_nxt = S_START;
        end else if (w_slot_end) begin
            case (r_state)
                S_START: w_state_nxt = S_ADDR;
                S_ADDR:  if (r_bit == 3'd7) w_state_nxt = S_AACK;
                S_AACK:  w_state_nxt = r_nack ? S_STOP : (r_addr_byte[0] ? S_READ : S_WRITE);
                S_WRITE: if (r_bit == 3'd7) w_state_nxt = S_WACK;
                S_WACK:  w_state_nxt = S_STOP;
                S_READ:  if (r_bit == 3'd7) w_state_nxt = S_MACK;
                S_MACK:  w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        w_q_nxt   = 2'd0;
        w_bit_nxt = 3'd0;
        if (r_state != S_IDLE) begin
            w_cnt_nxt = w_cnt_end ? '0 : r_cnt + c_CNT_W'(1);
            w_q_nxt   = w_cnt_end ? r_q + 2'd1 : r_q;
            w_bit_nxt = r_bit;
            if (w_slot_end && ((r_state == S_ADDR) || (r_state == S_WRITE) || (r_state == S_READ)))
                w_bit_nxt = r_bit + 3'd1;
        end
    end

    // Bus levels are computed for the upcoming position so the registered pins line up with it
    always_comb begin
        w_scl_nxt = 1'b1;
        w_rel_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_rel_nxt = ~w_q_nxt[1];
            S_ADDR: begin
                w_scl_nxt = w_q_nxt[1];
                w_rel_nxt = r_addr_byte[3'd7 - w_bit_nxt];
            end
            S_WRITE: begin
                w_scl_nxt = w_q_nxt[1];
                w_rel_nxt = r_wdata[3'd7 - w_bit_nxt];
            end
            S_AACK, S_WACK, S_READ, S_MACK: w_scl_nxt = w_q_nxt[1];
            S_STOP: begin
                w_scl_nxt = (w_q_nxt != 2'd0);
                w_rel_nxt = w_q_nxt[1];
            end
            default: begin
                w_scl_nxt = 1'b1;
                w_rel_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_scl     <= 1'b1;
            r_sda_rel <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_q       <= w_q_nxt;
            r_bit     <= w_bit_nxt;
            r_scl     <= w_scl_nxt;
            r_sda_rel <= w_rel_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy      <= 1'b0;
            r_ack_err   <= 1'b0;
            r_nack      <= 1'b0;
            r_addr_byte <= 8'd0;
            r_wdata     <= 8'd0;
            r_sr        <= 8'd0;
            r_rdata     <= 8'd0;
        end else begin
            if (w_accept) begin
                r_busy      <= 1'b1;
                r_ack_err   <= 1'b0;
                r_nack      <= 1'b0;
                r_addr_byte <= {cmd_addr, cmd_rw};
                r_wdata     <= cmd_wdata;
            end else if (w_done_nxt) begin
                r_busy    <= 1'b0;
                r_ack_err <= r_nack;
                // in a read the only ACK slot is the address one
                if (r_addr_byte[0] && !r_nack) r_rdata <= r_sr;
            end
            if (w_sample) begin
                if (((r_state == S_AACK) || (r_state == S_WACK)) && SDA_i) r_nack <= 1'b1;
                if (r_state == S_READ) r_sr <= {r_sr[6:0], SDA_i};
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign ack_err   = r_ack_err;
    assign rdata     = r_rdata;
    assign SCL_o     = r_scl;
    assign SDA_o     = r_sda_rel;
    assign SDA_in_en = r_sda_rel;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`default_nettype none
// Testbench for i2c_master: table vectors, random transactions against a
// transaction-level model, and hand-written busy/done/reset sequences.
module tb_i2c_master;

    localparam int         CLK_DIV  = 4;
    localparam int         SLOT     = 4 * CLK_DIV;
    localparam logic [6:0] SLV_ADDR = 7'h53;

    logic       clk       = 1'b0;
    logic       rstn      = 1'b1;
    logic       cmd_start = 1'b0;
    logic [6:0] cmd_addr  = 7'd0;
    logic       cmd_rw    = 1'b0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       busy, done, ack_err;
    logic [7:0] rdata;
    logic       SCL_o, SDA_o, SDA_in_en;
    logic       sda_line;
    logic       slv_pull  = 1'b0;

    // open-drain bus: low if either side pulls
    assign sda_line = ~((~SDA_in_en & ~SDA_o) | slv_pull);

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_start (cmd_start),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .rdata     (rdata),
        .SCL_o     (SCL_o),
        .SDA_i     (sda_line),
        .SDA_o     (SDA_o),
        .SDA_in_en (SDA_in_en)
    );

    always #5 clk = ~clk;

    int cyc_now = 0;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [7:0]  wdata;
        logic        wack;
        logic [7:0]  sdata;
        logic        poke;
        int          exp_cyc;
        logic        exp_err;
        logic [7:0]  exp_rdata;
        logic [17:0] exp_bits;
        int          exp_n;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    int acc_cyc, st0, sp0;
    logic [7:0] rd_shadow;

    // ---------------- bus slave + protocol monitor ----------------
    logic        slv_wack  = 1'b1;
    logic [7:0]  slv_rdata = 8'h00;
    logic        prev_scl  = 1'b1, prev_sda = 1'b1;
    logic        pend = 1'b0, pend_bit = 1'b0, in_txn = 1'b0;
    logic        match = 1'b0, rwb = 1'b0;
    logic [17:0] bits_v = '0;
    int          nbits = 0, mon_k = 0;
    int          start_cnt = 0, stop_cnt = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            slv_pull = 1'b0; pend = 1'b0; in_txn = 1'b0;
            prev_scl = 1'b1; prev_sda = 1'b1;
        end else begin
            if (prev_scl && SCL_o && prev_sda && !sda_line) begin
                start_cnt++; bits_v = '0; nbits = 0; pend = 1'b0; in_txn = 1'b1;
            end else if (prev_scl && SCL_o && !prev_sda && sda_line) begin
                stop_cnt++; pend = 1'b0; in_txn = 1'b0; slv_pull = 1'b0;
            end else if (!prev_scl && SCL_o) begin
                pend = 1'b1; pend_bit = sda_line;
            end else if (prev_scl && !SCL_o && in_txn) begin
                if (pend) begin
                    bits_v = {bits_v[16:0], pend_bit}; nbits++; pend = 1'b0;
                end
                mon_k = nbits;
                if (mon_k == 8) begin
                    match = (bits_v[7:1] == SLV_ADDR); rwb = bits_v[0];
                end
                slv_pull = 1'b0;
                if (mon_k == 8) slv_pull = match;
                else if (mon_k >= 9 && mon_k <= 16) slv_pull = match && rwb && !slv_rdata[16 - mon_k];
                else if (mon_k == 17) slv_pull = match && !rwb && slv_wack;
            end
            prev_scl = SCL_o;
            prev_sda = sda_line;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t make_vec(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                                      input logic wack, input logic [7:0] sd, input logic [7:0] prev);
        vec_t        v;
        logic        pres;
        logic [7:0]  hdr, dat;
        logic [17:0] b;
        int          n;
        pres = (a == SLV_ADDR);
        hdr  = {a, rw};
        dat  = rw ? sd : wd;
        b    = '0;
        n    = 0;
        for (int i = 7; i >= 0; i--) begin b = {b[16:0], hdr[i]}; n++; end
        b = {b[16:0], ~pres}; n++;
        if (pres) begin
            for (int i = 7; i >= 0; i--) begin b = {b[16:0], dat[i]}; n++; end
            b = {b[16:0], rw ? 1'b1 : ~wack}; n++;
        end
        v.addr = a; v.rw = rw; v.wdata = wd; v.wack = wack; v.sdata = sd; v.poke = 1'b0;
        v.exp_bits  = b;
        v.exp_n     = n;
        v.exp_cyc   = (pres ? 20 : 11) * SLOT;
        v.exp_err   = ~pres | (~rw & ~wack);
        v.exp_rdata = (rw && pres) ? sd : prev;
        return v;
    endfunction

    task automatic issue(input logic [6:0] a, input logic rw, input logic [7:0] wd);
        @(negedge clk);
        cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        acc_cyc = cyc_now; st0 = start_cnt; sp0 = stop_cnt;
    endtask

    task automatic wait_done(output int lat);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100 * SLOT) begin
            @(posedge clk); #1; n++;
        end
        check("done_seen", 32'(done), 32'd1);
        lat = cyc_now - acc_cyc;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        slv_wack = v.wack; slv_rdata = v.sdata;
        issue(v.addr, v.rw, v.wdata);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        if (v.poke) begin
            repeat (40) @(negedge clk);
            cmd_addr = 7'h10; cmd_rw = ~v.rw; cmd_wdata = ~v.wdata; cmd_start = 1'b1;
            @(negedge clk);
            cmd_start = 1'b0;
        end
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_cyc));
        check({tag, "_ack_err"}, 32'(ack_err), 32'(v.exp_err));
        check({tag, "_rdata"}, 32'(rdata), 32'(v.exp_rdata));
        check({tag, "_bits"}, 32'(bits_v), 32'(v.exp_bits));
        check({tag, "_nbits"}, 32'(nbits), 32'(v.exp_n));
        check({tag, "_starts"}, 32'(start_cnt - st0), 32'd1);
        check({tag, "_stops"}, 32'(stop_cnt - sp0), 32'd1);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        if (v.poke) begin
            repeat (3 * SLOT) @(posedge clk);
            #1;
            check({tag, "_no_second_busy"}, 32'(busy), 32'd0);
            check({tag, "_no_second_start"}, 32'(start_cnt - st0), 32'd1);
        end
        rd_shadow = v.exp_rdata;
    endtask

    // ---------------- test ----------------
    vec_t tbl[6];
    vec_t rv;
    int   lat;

    initial begin
        tbl[0] = '{7'h53, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 320, 1'b0, 8'h00,
                   {7'h53, 1'b0, 1'b0, 8'hA5, 1'b0}, 18};
        tbl[1] = '{7'h53, 1'b1, 8'h00, 1'b1, 8'h7E, 1'b0, 320, 1'b0, 8'h7E,
                   {7'h53, 1'b1, 1'b0, 8'h7E, 1'b1}, 18};
        tbl[2] = '{7'h21, 1'b0, 8'hC3, 1'b1, 8'h00, 1'b0, 176, 1'b1, 8'h7E,
                   {9'd0, 7'h21, 1'b0, 1'b1}, 9};
        tbl[3] = '{7'h53, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b1, 320, 1'b1, 8'h7E,
                   {7'h53, 1'b0, 1'b0, 8'h3C, 1'b1}, 18};
        tbl[4] = '{7'h21, 1'b1, 8'h00, 1'b1, 8'hAA, 1'b0, 176, 1'b1, 8'h7E,
                   {9'd0, 7'h21, 1'b1, 1'b1}, 9};
        tbl[5] = '{7'h53, 1'b1, 8'h00, 1'b1, 8'h81, 1'b0, 320, 1'b0, 8'h81,
                   {7'h53, 1'b1, 1'b0, 8'h81, 1'b1}, 18};

        // reset values, observed while reset is held
        #2 rstn = 1'b0;
        #1;
        check("rst_scl", 32'(SCL_o), 32'd1);
        check("rst_sda_in_en", 32'(SDA_in_en), 32'd1);
        check("rst_sda_o", 32'(SDA_o), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        rd_shadow = 8'h00;

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 8; i++) begin
            logic [6:0] a;
            a = ($urandom % 2 == 0) ? SLV_ADDR : 7'($urandom);
            if (($urandom % 2 == 1) && a == SLV_ADDR) a = 7'h2C;
            rv = make_vec(a, 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                          8'($urandom), rd_shadow);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // cmd_start in the done cycle is ignored; one cycle later it is accepted
        slv_wack = 1'b1;
        issue(SLV_ADDR, 1'b0, 8'h96);
        wait_done(lat);
        check("dc_latency", 32'(lat), 32'(20 * SLOT));
        cmd_addr = 7'h22; cmd_rw = 1'b0; cmd_start = 1'b1;
        @(posedge clk); #1;
        check("dc_ignored_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        cmd_start = 1'b0;
        check("dc_accept_busy", 32'(busy), 32'd1);
        acc_cyc = cyc_now;
        wait_done(lat);
        check("dc2_latency", 32'(lat), 32'(11 * SLOT));
        check("dc2_ack_err", 32'(ack_err), 32'd1);
        @(posedge clk); #1;

        // asynchronous reset in the middle of data bit 3 of a write (SCL low, SDA driven 0)
        issue(SLV_ADDR, 1'b0, 8'h4A);
        repeat (13 * SLOT + 1) @(posedge clk);
        #1;
        check("mid_pre_scl", 32'(SCL_o), 32'd0);
        check("mid_pre_sda_en", 32'(SDA_in_en), 32'd0);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_scl", 32'(SCL_o), 32'd1);
        check("mid_rst_sda_en", 32'(SDA_in_en), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_rdata", 32'(rdata), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        rd_shadow = 8'h00;
        rv = make_vec(SLV_ADDR, 1'b0, 8'h69, 1'b1, 8'h00, rd_shadow);
        run_vec(rv, "post_rst_wr");
        rv = make_vec(SLV_ADDR, 1'b1, 8'h00, 1'b1, 8'hC6, rd_shadow);
        run_vec(rv, "post_rst_rd");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
